// File: rtl/riscv_pkg.sv
// Shared riscv core definitions: register address type, x0 index and the
// write-back trace record used by the regfile and the core top.
package riscv_pkg;

    localparam int XLEN         = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int REG_AW       = $clog2(NUM_REGS_DEF);
    localparam int X0_IDX       = 0;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t X0 = reg_addr_t'(X0_IDX);

    typedef struct packed {
        logic             valid;
        reg_addr_t        num;
        logic [XLEN-1:0]  data;
    } trace_t;

endpackage

// File: rtl/riscv_regfile_sb_if.sv
// Register file bus: read ports, write-back, pend marking and trace outputs.
interface riscv_regfile_sb_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD-1:0][AW-1:0]     rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             busy;
    logic                          wr_en;
    logic [AW-1:0]                 wr_addr;
    logic [DATA_W-1:0]             wr_data;
    logic                          pend_set;
    logic [AW-1:0]                 pend_addr;
    logic                          reg_write_sig;
    logic [AW-1:0]                 reg_num;
    logic [DATA_W-1:0]             reg_data;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr,
        input  rd_data, busy, reg_write_sig, reg_num, reg_data
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, pend_set, pend_addr,
        output rd_data, busy, reg_write_sig, reg_num, reg_data
    );

endinterface

// File: rtl/riscv_regfile_sb_read_port.sv
// One combinational read port: x0 forcing, optional write-back forwarding
// and the matching busy flag.
module regfile_read_port #(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]     rd_addr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] array_data,
    input  logic              pending,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    logic hit;

    always_comb begin
        hit     = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);
        rd_data = '0;
        busy    = 1'b0;
        if (rd_addr != '0) begin
            rd_data = hit ? wr_data : array_data;
            // A forwarded write is the result the reader was waiting for.
            busy    = pending & ~hit;
        end
    end

endmodule

// File: rtl/riscv_regfile_sb.sv
// Integer register file with per-register pending scoreboard and a
// registered write-back trace.
module riscv_regfile_sb
    import riscv_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1
) (
    input  logic               clk,
    input  logic               reset,
    riscv_regfile_sb_if.slave  bus
);

    localparam int AW = $clog2(NUM_REGS);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(X0_IDX);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic                wr_ok;
    logic                pend_ok;

    assign wr_ok   = bus.wr_en    && (bus.wr_addr   != ZERO_ADDR);
    assign pend_ok = bus.pend_set && (bus.pend_addr != ZERO_ADDR);

    // Pend is applied after the write so a same-edge new producer wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            pending <= '0;
        end else begin
            if (wr_ok) begin
                regs[bus.wr_addr]    <= bus.wr_data;
                pending[bus.wr_addr] <= 1'b0;
            end
            if (pend_ok) pending[bus.pend_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.reg_write_sig <= 1'b0;
            bus.reg_num       <= '0;
            bus.reg_data      <= '0;
        end else begin
            bus.reg_write_sig <= wr_ok;
            bus.reg_num       <= bus.wr_addr;
            bus.reg_data      <= bus.wr_data;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        regfile_read_port #(
            .DATA_W (DATA_W),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_port (
            .rd_addr    (bus.rd_addr[g]),
            .wr_en      (bus.wr_en),
            .wr_addr    (bus.wr_addr),
            .wr_data    (bus.wr_data),
            .array_data (regs[bus.rd_addr[g]]),
            .pending    (pending[bus.rd_addr[g]]),
            .rd_data    (bus.rd_data[g]),
            .busy       (bus.busy[g])
        );
    end

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Bench for riscv_regfile_sb: bypass and non-bypass 2-port instances share
// stimulus; a 4-port 64-bit instance covers the wide configuration.
module tb_riscv_regfile_sb;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    riscv_regfile_sb_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) ifa ();
    riscv_regfile_sb_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) ifb ();
    riscv_regfile_sb_if #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(4)) ifc ();

    assign ifb.rd_addr   = ifa.rd_addr;
    assign ifb.wr_en     = ifa.wr_en;
    assign ifb.wr_addr   = ifa.wr_addr;
    assign ifb.wr_data   = ifa.wr_data;
    assign ifb.pend_set  = ifa.pend_set;
    assign ifb.pend_addr = ifa.pend_addr;

    riscv_regfile_sb #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS(1))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));
    riscv_regfile_sb #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS(0))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));
    riscv_regfile_sb #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(4), .BYPASS(1))
        dut_c (.clk(clk), .reset(reset), .bus(ifc));

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ps;
        logic [4:0]  pa;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] ad0; logic ab0; logic [31:0] ad1; logic ab1;
        logic [31:0] bd0; logic bb0; logic [31:0] bd1; logic bb1;
    } vec_t;

    typedef struct {
        logic        v;
        logic [4:0]  n;
        logic [31:0] d;
    } trace_exp_t;

    vec_t       vecs [$];
    trace_exp_t tq   [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic ps, input logic [4:0] pa, input logic [4:0] r0, input logic [4:0] r1,
        input logic [31:0] ad0, input logic ab0, input logic [31:0] ad1, input logic ab1,
        input logic [31:0] bd0, input logic bb0, input logic [31:0] bd1, input logic bb1);
        vec_t x;
        x.we = we; x.wa = wa; x.wd = wd; x.ps = ps; x.pa = pa; x.r0 = r0; x.r1 = r1;
        x.ad0 = ad0; x.ab0 = ab0; x.ad1 = ad1; x.ab1 = ab1;
        x.bd0 = bd0; x.bb0 = bb0; x.bd1 = bd1; x.bb1 = bb1;
        return x;
    endfunction

    task automatic chk_trace(input string tag, input trace_exp_t e);
        chk({tag, "_a_sig"},  64'(ifa.reg_write_sig), 64'(e.v));
        chk({tag, "_a_num"},  64'(ifa.reg_num),       64'(e.n));
        chk({tag, "_a_data"}, 64'(ifa.reg_data),      64'(e.d));
        chk({tag, "_b_sig"},  64'(ifb.reg_write_sig), 64'(e.v));
        chk({tag, "_b_num"},  64'(ifb.reg_num),       64'(e.n));
        chk({tag, "_b_data"}, 64'(ifb.reg_data),      64'(e.d));
    endtask

    task automatic chk_all_zero(input string tag);
        trace_exp_t z;
        z.v = 1'b0; z.n = '0; z.d = '0;
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s_a_d%0d", tag, p), 64'(ifa.rd_data[p]), 64'd0);
            chk($sformatf("%s_a_b%0d", tag, p), 64'(ifa.busy[p]),    64'd0);
            chk($sformatf("%s_b_d%0d", tag, p), 64'(ifb.rd_data[p]), 64'd0);
            chk($sformatf("%s_b_b%0d", tag, p), 64'(ifb.busy[p]),    64'd0);
        end
        chk_trace(tag, z);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        trace_exp_t e;
        logic [63:0] wide;
        wide = 64'hFFFF_0000_FFFF_0000;

        ifa.rd_addr = '0; ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0;
        ifa.pend_set = 1'b0; ifa.pend_addr = '0;
        ifc.rd_addr = '0; ifc.wr_en = 1'b0; ifc.wr_addr = '0; ifc.wr_data = '0;
        ifc.pend_set = 1'b0; ifc.pend_addr = '0;

        //           we wa  wd            ps pa  r0 r1  A: d0 b0 d1 b1                       B: d0 b0 d1 b1
        vecs.push_back(v(0, 0, 32'h0,        0, 0,  5, 7,  32'h0, 0, 32'h0, 0,               32'h0, 0, 32'h0, 0));
        vecs.push_back(v(1, 5, 32'hDEADBEEF, 0, 0,  5, 0,  32'hDEADBEEF, 0, 32'h0, 0,        32'h0, 0, 32'h0, 0));
        vecs.push_back(v(0, 0, 32'h0,        0, 0,  5, 5,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0));
        vecs.push_back(v(1, 0, 32'h1234,     1, 0,  0, 0,  32'h0, 0, 32'h0, 0,               32'h0, 0, 32'h0, 0));
        vecs.push_back(v(0, 0, 32'h0,        1, 7,  7, 7,  32'h0, 0, 32'h0, 0,               32'h0, 0, 32'h0, 0));
        vecs.push_back(v(0, 0, 32'h0,        0, 0,  7, 7,  32'h0, 1, 32'h0, 1,               32'h0, 1, 32'h0, 1));
        vecs.push_back(v(0, 0, 32'h0,        0, 0,  7, 7,  32'h0, 1, 32'h0, 1,               32'h0, 1, 32'h0, 1));
        vecs.push_back(v(0, 0, 32'h0,        0, 0,  7, 7,  32'h0, 1, 32'h0, 1,               32'h0, 1, 32'h0, 1));
        vecs.push_back(v(1, 7, 32'hA5,       0, 0,  7, 7,  32'hA5, 0, 32'hA5, 0,             32'h0, 1, 32'h0, 1));
        vecs.push_back(v(0, 0, 32'h0,        0, 0,  7, 7,  32'hA5, 0, 32'hA5, 0,             32'hA5, 0, 32'hA5, 0));
        vecs.push_back(v(1, 9, 32'h11,       1, 9,  9, 9,  32'h11, 0, 32'h11, 0,             32'h0, 0, 32'h0, 0));
        vecs.push_back(v(0, 0, 32'h0,        0, 0,  9, 9,  32'h11, 1, 32'h11, 1,             32'h11, 1, 32'h11, 1));
        vecs.push_back(v(1, 4, 32'h55,       1, 3,  3, 4,  32'h0, 0, 32'h55, 0,              32'h0, 0, 32'h0, 0));
        vecs.push_back(v(0, 0, 32'h0,        0, 0,  3, 4,  32'h0, 1, 32'h55, 0,              32'h0, 1, 32'h55, 0));

        // Reset held, then released away from the rising edge.
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        ifa.rd_addr[0] = 5'd5; ifa.rd_addr[1] = 5'd7;
        #1;
        chk_all_zero("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            ifa.wr_en = vecs[i].we; ifa.wr_addr = vecs[i].wa; ifa.wr_data = vecs[i].wd;
            ifa.pend_set = vecs[i].ps; ifa.pend_addr = vecs[i].pa;
            ifa.rd_addr[0] = vecs[i].r0; ifa.rd_addr[1] = vecs[i].r1;
            #1;
            chk($sformatf("v%0d_a_d0", i), 64'(ifa.rd_data[0]), 64'(vecs[i].ad0));
            chk($sformatf("v%0d_a_b0", i), 64'(ifa.busy[0]),    64'(vecs[i].ab0));
            chk($sformatf("v%0d_a_d1", i), 64'(ifa.rd_data[1]), 64'(vecs[i].ad1));
            chk($sformatf("v%0d_a_b1", i), 64'(ifa.busy[1]),    64'(vecs[i].ab1));
            chk($sformatf("v%0d_b_d0", i), 64'(ifb.rd_data[0]), 64'(vecs[i].bd0));
            chk($sformatf("v%0d_b_b0", i), 64'(ifb.busy[0]),    64'(vecs[i].bb0));
            chk($sformatf("v%0d_b_d1", i), 64'(ifb.rd_data[1]), 64'(vecs[i].bd1));
            chk($sformatf("v%0d_b_b1", i), 64'(ifb.busy[1]),    64'(vecs[i].bb1));
            e.v = vecs[i].we && (vecs[i].wa != 5'd0);
            e.n = vecs[i].wa;
            e.d = vecs[i].wd;
            tq.push_back(e);
            @(posedge clk); #1;
            if (tq.size() == 0) begin
                chk($sformatf("v%0d_trace_queue", i), 64'd0, 64'd1);
            end else begin
                e = tq.pop_front();
                chk_trace($sformatf("v%0d_trace", i), e);
            end
        end

        // Mid-cycle reset with x3 pending and x4 written: everything clears at once.
        #2 reset = 1'b0;
        #1;
        tq.delete();
        chk_all_zero("midrst");
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("postrst_a_b_x3", 64'(ifa.busy[0]),    64'd0);
        chk("postrst_a_d_x4", 64'(ifa.rd_data[1]), 64'd0);
        chk("postrst_b_b_x3", 64'(ifb.busy[0]),    64'd0);
        chk("postrst_b_d_x4", 64'(ifb.rd_data[1]), 64'd0);

        // Wide instance: four ports, two of them forwarding the same write.
        ifc.rd_addr[0] = 4'd1; ifc.rd_addr[1] = 4'd15; ifc.rd_addr[2] = 4'd0; ifc.rd_addr[3] = 4'd15;
        ifc.wr_en = 1'b1; ifc.wr_addr = 4'd15; ifc.wr_data = wide;
        #1;
        chk("c_byp_d0", ifc.rd_data[0], 64'd0);
        chk("c_byp_d1", ifc.rd_data[1], wide);
        chk("c_byp_d2", ifc.rd_data[2], 64'd0);
        chk("c_byp_d3", ifc.rd_data[3], wide);
        chk("c_byp_busy", 64'(ifc.busy), 64'd0);
        @(posedge clk); #1;
        ifc.wr_en = 1'b0; ifc.wr_addr = '0; ifc.wr_data = '0;
        ifc.pend_set = 1'b1; ifc.pend_addr = 4'd1;
        #1;
        chk("c_tr_sig",  64'(ifc.reg_write_sig), 64'd1);
        chk("c_tr_num",  64'(ifc.reg_num),       64'd15);
        chk("c_tr_data", ifc.reg_data,           wide);
        chk("c_arr_d1", ifc.rd_data[1], wide);
        chk("c_arr_d3", ifc.rd_data[3], wide);
        chk("c_pend_same_cycle", 64'(ifc.busy), 64'd0);
        @(posedge clk); #1;
        ifc.pend_set = 1'b0; ifc.pend_addr = '0;
        #1;
        chk("c_pend_busy", 64'(ifc.busy), 64'b0001);
        chk("c_tr_pulse",  64'(ifc.reg_write_sig), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_regfile_sb.md
# riscv_regfile_sb

Parametrised integer register file with a per-register pending scoreboard and registered write-back trace, for the next-generation `riscv` core. Sits between decode and write-back inside the datapath. Provides NUM_RD combinational read ports with optional write-to-read bypass and a busy flag per read port so the controller can stall on outstanding loads or multi-cycle results. Drives the core's `reg_num`/`reg_data`/`reg_write_sig` trace outputs.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of architectural registers (power of two, ≥2); AW = $clog2(NUM_REGS)
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write forwarded to reads and clears busy; 0 = no forwarding
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; state cleared while low
- rd_addr  in  NUM_RD×AW  read addresses
- rd_data  out  NUM_RD×DATA_W  read data, combinational
- busy  out  NUM_RD  read port i's register has an outstanding producer
- wr_en  in  1  write-back strobe
- wr_addr  in  AW  write-back register
- wr_data  in  DATA_W  write-back data
- pend_set  in  1  mark pend_addr as awaiting a result (issue of load/multi-cycle op)
- pend_addr  in  AW  register being marked
- reg_write_sig  out  1  trace: a write committed last cycle
- reg_num  out  AW  trace: register written
- reg_data  out  DATA_W  trace: data written

## Operation
- Storage: NUM_REGS×DATA_W array plus NUM_REGS pending bits. Register 0 reads 0 always, never written, never pending.
- Write: on clk with wr_en=1 and wr_addr≠0, array[wr_addr] ← wr_data and pending[wr_addr] ← 0.
- Pend: on clk with pend_set=1 and pend_addr≠0, pending[pend_addr] ← 1.
- Same-edge wr_en and pend_set on the same nonzero address: pend wins. Array takes wr_data, pending ends 1 (new producer overrides old).
- Read, BYPASS=1: rd_data[i] = 0 if rd_addr[i]=0; else wr_data if wr_en and wr_addr=rd_addr[i]; else array.
- Read, BYPASS=0: rd_data[i] = array value (0 for x0).
- busy[i] = pending[rd_addr[i]], except when BYPASS=1 and wr_en with wr_addr=rd_addr[i]; then busy[i]=0. pend_set in the current cycle does not affect busy until the next cycle.
- Trace: on every clk, reg_write_sig ← wr_en & (wr_addr≠0), reg_num ← wr_addr, reg_data ← wr_data. Writes to x0 are not traced.
- wr_en to a non-pending register is legal; plain ALU write-back uses it.

## Timing
- Read and busy: 0-cycle combinational from rd_addr, wr_*, and state.
- Write visible through the array: next cycle. Through bypass: same cycle.
- Trace: exactly 1 cycle after the write edge. reg_write_sig is a 1-cycle pulse per write.
- Reset (async assert, synchronous-safe deassert by the top level) clears the following mid-operation, including pending bits, so no stall survives reset:
  - all array entries to 0
  - all pending bits to 0
  - reg_write_sig, reg_num, and reg_data to 0
- Output reset values: rd_data=0, busy=0, reg_write_sig=0, reg_num=0, reg_data=0.

## Structure
- The shared `riscv_pkg` holds:
  - the register address type (derived from NUM_REGS)
  - the x0 index constant
  - a trace struct (valid, num, data) reused by the core top
- One sub-module, `regfile_read_port`: one instance per read port, generated NUM_RD times. It contains the x0 mux, bypass compare, and busy logic.
- Array and pending bits stay in the parent. No memory macro; flops, so reset clears them.

## Test plan
- Reset, then write x5=0xDEADBEEF. The next cycle rd_addr[0]=5 gives rd_data[0]=0xDEADBEEF. One cycle after the write, reg_write_sig=1, reg_num=5, reg_data=0xDEADBEEF.
- Write x0=0x1234 with pend_set on x0. rd_addr=0 gives rd_data=0, busy=0, and reg_write_sig stays 0.
- pend_set x7, then idle 3 cycles: busy=1 for rd_addr=7 on both ports. Then wr_en x7=0xA5:
  - BYPASS=1: busy=0 and rd_data=0xA5 in that same cycle.
  - BYPASS=0: busy stays 1 that cycle, falls next cycle.
- Same edge: wr_en x9=0x11 and pend_set x9. The next cycle shows busy=1 for x9 and array x9=0x11 (visible via BYPASS=0 read).
- pend_set x3, write x4=0x55, then assert reset low mid-cycle. Outputs go to 0 immediately. After release, busy=0 for x3 and rd_data=0 for x4.
- NUM_RD=4, NUM_REGS=16, DATA_W=64: four ports read x1, x15, x0, x15 while writing x15=0xFFFF_0000_FFFF_0000. The expected rd_data is 0, bypass value, 0, bypass value.
